// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-addressed instruction memory, big-endian byte order.
// Defining IMEM_LOADER_CHECKSUM_EN adds a checksum output: the sum of the words accepted in a load.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddress,
  input  logic [3:0]            loadCount,
  input  logic                  wordValid,
  input  logic [31:0]           wordData,
  output logic                  wordReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memWriteAddress,
  output logic [7:0]            memWriteData,
  output logic                  busy,
  output logic                  done,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  output logic [3:0]            wordsWritten
);
  localparam logic [3:0] MaxWords = 4'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [1:0]            r_byte_idx, w_byte_idx_next;
  logic [3:0]            r_remaining, w_remaining_next;
  logic [3:0]            r_words_written, w_words_written_next;
  logic [31:0]           r_word, w_word_next;
  logic [3:0]            w_load_words;
  logic                  w_handshake;

  assign w_load_words = (loadCount > MaxWords) ? MaxWords : loadCount;
  assign w_handshake  = (r_state == StAccept) && wordValid;
  assign wordsWritten = r_words_written;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_addr          <= '0;
      r_byte_idx      <= '0;
      r_remaining     <= '0;
      r_words_written <= '0;
      r_word          <= '0;
    end else begin
      r_state         <= w_state_next;
      r_addr          <= w_addr_next;
      r_byte_idx      <= w_byte_idx_next;
      r_remaining     <= w_remaining_next;
      r_words_written <= w_words_written_next;
      r_word          <= w_word_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_addr_next          = r_addr;
    w_byte_idx_next      = r_byte_idx;
    w_remaining_next     = r_remaining;
    w_words_written_next = r_words_written;
    w_word_next          = r_word;
    wordReady            = 1'b0;
    memWriteEnable       = 1'b0;
    memWriteAddress      = '0;
    memWriteData         = '0;
    busy                 = 1'b0;
    done                 = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_words_written_next = '0;
          if (loadCount == 4'd0) begin
            w_state_next = StDone;
          end else begin
            w_addr_next      = {baseAddress[ADDR_WIDTH-1:2], 2'b00};
            w_remaining_next = w_load_words;
            w_state_next     = StAccept;
          end
        end
      end
      StAccept: begin
        wordReady = 1'b1;
        busy      = 1'b1;
        if (w_handshake) begin
          w_word_next     = wordData;
          w_byte_idx_next = 2'd0;
          w_state_next    = StWrite;
        end
      end
      StWrite: begin
        busy            = 1'b1;
        memWriteEnable  = 1'b1;
        memWriteAddress = r_addr + ADDR_WIDTH'(r_byte_idx);
        // ~idx == 3 - idx, so byte 0 carries word[31:24]
        memWriteData    = 8'(r_word >> {~r_byte_idx, 3'b000});
        w_byte_idx_next = r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          w_addr_next          = r_addr + ADDR_WIDTH'(3'd4);
          w_words_written_next = r_words_written + 4'd1;
          w_remaining_next     = r_remaining - 4'd1;
          w_state_next         = (r_remaining == 4'd1) ? StDone : StAccept;
        end
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_checksum <= '0;
    end else if (w_handshake) begin
      r_checksum <= r_checksum + wordData;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule
